// File: rtl/store_buffer.sv
// ============================================================================
// store_buffer : posted store queue with byte strobes, in-order bus drain and
//                load-conflict detection. Optional STORE_BUF_MERGE_EN merge.
// Revision     : 1.0
// ============================================================================
`default_nettype none

package store_buffer_pkg;
  typedef enum logic [1:0] {
    MEM_SB   = 2'd0,
    MEM_SH   = 2'd1,
    MEM_SW   = 2'd2,
    MEM_NONE = 2'd3
  } mem_t;
endpackage

module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   push_valid,
  output logic                   push_ready,
  input  logic [31:0]            push_addr,
  input  logic [31:0]            push_wd,
  input  mem_t                   push_type,
  output logic                   dreq_valid,
  output logic [31:0]            dreq_addr,
  output logic [31:0]            dreq_data,
  output logic [3:0]             dreq_strobe,
  input  logic                   dreq_ready,
  input  logic [31:0]            ld_addr,
  output logic                   ld_conflict,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [29:0]      addr_q [DEPTH];
  logic [31:0]      data_q [DEPTH];
  logic [3:0]       strb_q [DEPTH];
  logic [DEPTH-1:0] valid_q;
  logic [PW-1:0]    head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]    count_q, count_d;

  logic       is_store, full, merge_hit, push_fire, alloc, pop;
  logic [3:0] new_strb;
  logic       unused_ld_lsb;

  assign unused_ld_lsb = &{1'b0, ld_addr[1:0]};

  always_comb begin
    new_strb = 4'b0000;
    is_store = 1'b1;
    case (push_type)
      MEM_SB:  new_strb = 4'b0001 << push_addr[1:0];
      MEM_SH:  new_strb = push_addr[1] ? 4'b1100 : 4'b0011;
      MEM_SW:  new_strb = 4'b1111;
      default: is_store = 1'b0;
    endcase
  end

  assign full = (count_q == CW'(DEPTH));

`ifdef STORE_BUF_MERGE_EN
  logic [PW-1:0] last_ptr;
  logic [31:0]   merge_data;
  logic          merge;

  assign last_ptr = tail_q - PW'(1);
  // The head is excluded (count >= 2) because it may be mid-handshake.
  assign merge_hit = is_store && (count_q >= CW'(2)) &&
                     (addr_q[last_ptr] == push_addr[31:2]);
  assign merge     = push_fire && merge_hit;

  always_comb begin
    merge_data = data_q[last_ptr];
    for (int b = 0; b < 4; b++) begin
      if (new_strb[b]) merge_data[8*b +: 8] = push_wd[8*b +: 8];
    end
  end
`else
  assign merge_hit = 1'b0;
`endif

  assign push_ready = !full || merge_hit;
  assign push_fire  = push_valid && push_ready;
  assign alloc      = push_fire && is_store && !merge_hit;
  assign pop        = dreq_valid && dreq_ready;

  always_comb begin
    head_d  = pop   ? head_q + PW'(1) : head_q;
    tail_d  = alloc ? tail_q + PW'(1) : tail_q;
    count_d = count_q;
    case ({alloc, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      valid_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
        strb_q[i] <= '0;
      end
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      for (int i = 0; i < DEPTH; i++) begin
        if (alloc && tail_q == PW'(i)) begin
          addr_q[i]  <= push_addr[31:2];
          data_q[i]  <= push_wd;
          strb_q[i]  <= new_strb;
          valid_q[i] <= 1'b1;
        end
`ifdef STORE_BUF_MERGE_EN
        else if (merge && last_ptr == PW'(i)) begin
          data_q[i] <= merge_data;
          strb_q[i] <= strb_q[i] | new_strb;
        end
`endif
        // Alloc and pop never target the same slot: that needs empty or full.
        if (pop && head_q == PW'(i)) valid_q[i] <= 1'b0;
      end
    end
  end

  always_comb begin
    ld_conflict = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && addr_q[i] == ld_addr[31:2]) ld_conflict = 1'b1;
    end
  end

  assign empty       = (count_q == '0);
  assign count       = count_q;
  assign dreq_valid  = !empty;
  assign dreq_addr   = {addr_q[head_q], 2'b00};
  assign dreq_data   = data_q[head_q];
  assign dreq_strobe = strb_q[head_q];

endmodule

`default_nettype wire

// File: tb/tb_store_buffer.sv
// ============================================================================
// tb_store_buffer : scoreboard bench for store_buffer (directed vectors).
// Revision        : 1.0
// ============================================================================
`default_nettype none

module tb_store_buffer;
  import store_buffer_pkg::*;

  localparam int DEPTH = 4;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  s;
  } exp_t;

  logic        clk = 1'b0;
  logic        resetn;
  logic        push_valid;
  logic        push_ready;
  logic [31:0] push_addr;
  logic [31:0] push_wd;
  mem_t        push_type;
  logic        dreq_valid;
  logic [31:0] dreq_addr;
  logic [31:0] dreq_data;
  logic [3:0]  dreq_strobe;
  logic        dreq_ready;
  logic [31:0] ld_addr;
  logic        ld_conflict;
  logic        empty;
  logic [$clog2(DEPTH):0] count;

  int   checks   = 0;
  int   failures = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  store_buffer #(.DEPTH(DEPTH)) dut (
    .clk(clk), .resetn(resetn),
    .push_valid(push_valid), .push_ready(push_ready), .push_addr(push_addr),
    .push_wd(push_wd), .push_type(push_type),
    .dreq_valid(dreq_valid), .dreq_addr(dreq_addr), .dreq_data(dreq_data),
    .dreq_strobe(dreq_strobe), .dreq_ready(dreq_ready),
    .ld_addr(ld_addr), .ld_conflict(ld_conflict), .empty(empty), .count(count)
  );

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    #2;
  endtask

  task automatic set_push(input logic v, input logic [31:0] a, input logic [31:0] wd, input mem_t t);
    push_valid = v;
    push_addr  = a;
    push_wd    = wd;
    push_type  = t;
  endtask

  task automatic expect_entry(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    sb.push_back('{a: a, d: d, s: s});
  endtask

  // Monitor: every completed bus handshake is checked against the scoreboard.
  always @(negedge clk) begin
    if (resetn === 1'b1 && dreq_valid === 1'b1 && dreq_ready === 1'b1) begin
      if (sb.size() == 0) begin
        chk("drain_unexpected", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("drain_addr", dreq_addr, e.a);
        chk("drain_data", dreq_data, e.d);
        chk("drain_strobe", {28'd0, dreq_strobe}, {28'd0, e.s});
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    resetn     = 1'b0;
    dreq_ready = 1'b0;
    ld_addr    = 32'h0;
    set_push(1'b0, 32'h0, 32'h0, MEM_SW);
    #12;
    chk("rst_dreq_valid", dreq_valid, 0);
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_push_ready", push_ready, 1);
    chk("rst_ld_conflict", ld_conflict, 0);
    chk("rst_dreq_data", dreq_data, 0);
    step;
    resetn = 1'b1;

    // Strobe generation with back-to-back push/pop.
    dreq_ready = 1'b1;
    set_push(1'b1, 32'h1003, 32'hAB000000, MEM_SB);
    expect_entry(32'h1000, 32'hAB000000, 4'b1000);
    step;
    set_push(1'b1, 32'h2002, 32'h55660000, MEM_SH);
    expect_entry(32'h2000, 32'h55660000, 4'b1100);
    settle;
    chk("sb_latency_valid", dreq_valid, 1);
    chk("sb_strobe_direct", {28'd0, dreq_strobe}, 32'h8);
    step;
    set_push(1'b1, 32'h3000, 32'hDEADBEEF, MEM_SW);
    expect_entry(32'h3000, 32'hDEADBEEF, 4'b1111);
    step;
    set_push(1'b0, 32'h0, 32'h0, MEM_SW);
    step;
    step;
    settle;
    chk("strobe_drained_empty", empty, 1);

    // Non-store type: accepted but not buffered.
    dreq_ready = 1'b0;
    set_push(1'b1, 32'h60, 32'h1, MEM_NONE);
    settle;
    chk("drop_push_ready", push_ready, 1);
    step;
    set_push(1'b0, 32'h0, 32'h0, MEM_SW);
    settle;
    chk("drop_count", count, 0);

    // Fill and backpressure.
    for (int i = 0; i < 4; i++) begin
      set_push(1'b1, 32'h10 * (i + 1), 32'hA0 + i, MEM_SW);
      expect_entry(32'h10 * (i + 1), 32'hA0 + i, 4'b1111);
      step;
    end
    set_push(1'b1, 32'h50, 32'hFF, MEM_SW);
    settle;
    chk("full_count", count, 4);
    chk("full_push_ready", push_ready, 0);
    step;
    set_push(1'b0, 32'h0, 32'h0, MEM_SW);
    settle;
    chk("full_refused_count", count, 4);
    dreq_ready = 1'b1;
    repeat (4) step;
    dreq_ready = 1'b0;
    settle;
    chk("full_drained_empty", empty, 1);

    // Simultaneous push and pop.
    set_push(1'b1, 32'h400, 32'h1, MEM_SW); expect_entry(32'h400, 32'h1, 4'hF); step;
    set_push(1'b1, 32'h404, 32'h2, MEM_SW); expect_entry(32'h404, 32'h2, 4'hF); step;
    set_push(1'b1, 32'h408, 32'h3, MEM_SW); expect_entry(32'h408, 32'h3, 4'hF);
    dreq_ready = 1'b1;
    settle;
    chk("simul_count_before", count, 2);
    step;
    dreq_ready = 1'b0;
    set_push(1'b1, 32'h40C, 32'h4, MEM_SW); expect_entry(32'h40C, 32'h4, 4'hF);
    settle;
    chk("simul_count_after", count, 2);
    step;
    set_push(1'b1, 32'h410, 32'h5, MEM_SW); expect_entry(32'h410, 32'h5, 4'hF); step;
    set_push(1'b1, 32'h414, 32'h6, MEM_SW);
    dreq_ready = 1'b1;
    settle;
    chk("full_pop_push_ready", push_ready, 0);
    step;
    set_push(1'b0, 32'h0, 32'h0, MEM_SW);
    settle;
    chk("full_pop_count", count, 3);
    repeat (3) step;
    dreq_ready = 1'b0;
    settle;
    chk("simul_drained_empty", empty, 1);

    // Load conflict.
    set_push(1'b1, 32'h100, 32'h100, MEM_SW); expect_entry(32'h100, 32'h100, 4'hF); step;
    set_push(1'b1, 32'h200, 32'h200, MEM_SW); expect_entry(32'h200, 32'h200, 4'hF);
    ld_addr = 32'h203;
    settle;
    chk("ld_push_same_cycle", ld_conflict, 0);
    step;
    set_push(1'b0, 32'h0, 32'h0, MEM_SW);
    settle;
    chk("ld_hit_203", ld_conflict, 1);
    ld_addr = 32'h300;
    settle;
    chk("ld_miss_300", ld_conflict, 0);
    ld_addr = 32'h100;
    dreq_ready = 1'b1;
    settle;
    chk("ld_hit_popping", ld_conflict, 1);
    step;
    step;
    dreq_ready = 1'b0;
    ld_addr = 32'h203;
    settle;
    chk("ld_after_pop", ld_conflict, 0);

    // Merge (or plain allocation when the macro is off).
    set_push(1'b1, 32'h0, 32'h11111111, MEM_SW); step;
    set_push(1'b1, 32'h8, 32'h00000022, MEM_SB); step;
    set_push(1'b1, 32'h9, 32'h00003300, MEM_SB); step;
    set_push(1'b0, 32'h0, 32'h0, MEM_SW);
    settle;
    expect_entry(32'h0, 32'h11111111, 4'b1111);
`ifdef STORE_BUF_MERGE_EN
    expect_entry(32'h8, 32'h00003322, 4'b0011);
    chk("merge_count", count, 2);
`else
    expect_entry(32'h8, 32'h00000022, 4'b0001);
    expect_entry(32'h8, 32'h00003300, 4'b0010);
    chk("nomerge_count", count, 3);
`endif
    dreq_ready = 1'b1;
    repeat (4) step;
    dreq_ready = 1'b0;
    settle;
    chk("merge_drained_empty", empty, 1);

    // Reset mid-drain discards everything.
    set_push(1'b1, 32'h500, 32'h50, MEM_SW); expect_entry(32'h500, 32'h50, 4'hF); step;
    dreq_ready = 1'b1;
    set_push(1'b1, 32'h504, 32'h51, MEM_SW); expect_entry(32'h504, 32'h51, 4'hF); step;
    dreq_ready = 1'b0;
    set_push(1'b1, 32'h508, 32'h52, MEM_SW); expect_entry(32'h508, 32'h52, 4'hF); step;
    set_push(1'b1, 32'h50C, 32'h53, MEM_SW); expect_entry(32'h50C, 32'h53, 4'hF); step;
    set_push(1'b0, 32'h0, 32'h0, MEM_SW);
    settle;
    chk("pre_reset_count", count, 3);
    dreq_ready = 1'b1;
    #1;
    resetn = 1'b0;
    sb.delete();
    #1;
    chk("rst_mid_valid", dreq_valid, 0);
    chk("rst_mid_count", count, 0);
    chk("rst_mid_data", dreq_data, 0);
    chk("rst_mid_addr", dreq_addr, 0);
    step;
    resetn = 1'b1;
    dreq_ready = 1'b0;
    settle;
    chk("post_reset_push_ready", push_ready, 1);
    chk("post_reset_empty", empty, 1);
    step;

    chk("scoreboard_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/store_buffer.md
# store_buffer

Posted store queue between the store-data aligner and the data bus. It accepts committed stores whose data is already byte-lane aligned, derives byte strobes from the address offset and access size, and buffers up to DEPTH stores. It drains them in order to the data bus over a valid/ready handshake. It also flags loads that hit a buffered word so the pipeline can stall them.

## Interface
- DEPTH, 4: entry count; power of two, ≥2.
- clk  in  1  clock, all state on rising edge.
- resetn  in  1  asynchronous, active-low reset.
- push_valid  in  1  store offered.
- push_ready  out  1  store can be accepted this cycle.
- push_addr  in  32  byte address of the store.
- push_wd  in  32  store data, already lane-aligned.
- push_type  in  mem_t  MEM_SB / MEM_SH / MEM_SW; any other value is dropped.
- dreq_valid  out  1  head entry presented to the bus.
- dreq_addr  out  32  word address of the head entry, {addr[31:2],2'b00}.
- dreq_data  out  32  head data.
- dreq_strobe  out  4  head byte enables.
- dreq_ready  in  1  bus accepts the head.
- ld_addr  in  32  load address to check.
- ld_conflict  out  1  combinational: some valid entry has word address == ld_addr[31:2].
- empty  out  1  no valid entries.
- count  out  $clog2(DEPTH)+1  number of valid entries.

## Operation
- Strobe derivation:
  - MEM_SW: 4'b1111.
  - MEM_SH: addr[1]=0 gives 4'b0011; addr[1]=1 gives 4'b1100.
  - MEM_SB: 4'b0001 << addr[1:0].
  - addr[0] is ignored for SH; addr[1:0] is ignored for SW. Misalignment is trapped upstream.
- Storage is a circular FIFO: head pointer, tail pointer, count. Each entry holds {word addr[31:2], data, strobe}.
- Push fire = push_valid & push_ready.
  - Store types allocate at the tail.
  - Other push_type values: push_ready still applies, but no entry is written and count is unchanged.
- Pop fire = dreq_valid & dreq_ready. The head advances and the entry is invalidated.
- Pointers wrap modulo DEPTH. count is updated by +1, −1 or 0 when push and pop fire in the same cycle.
- dreq_valid = !empty. dreq_* come from the head entry and stay stable until pop fires.
- ld_conflict compares against valid entries only. An entry pushed this cycle is not seen; an entry popped this cycle is still seen.

## Timing
- push_ready = (count != DEPTH). Push and pop in the same cycle never bypass each other.
- Latency: a push into an empty buffer appears on dreq_valid in the next cycle.
- Throughput: one push and one pop per cycle sustained.
- When full: push_ready=0; a pop in the same cycle frees a slot only from the following cycle.
- Reset (asynchronous assert, synchronous release):
  - pointers = 0, count = 0, empty = 1.
  - dreq_valid = 0; dreq_addr, dreq_data, dreq_strobe = 0.
  - ld_conflict = 0; push_ready = 1.
  - All entry contents are cleared to 0.
- Reset during a pending bus request discards all entries. No handshake completion is owed afterward.

## Configuration
- STORE_BUF_MERGE_EN defined:
  - A store push whose word address equals the tail (most recent) entry merges into it, provided count ≥ 2. The head is never merged because it may be mid-handshake.
  - Merge rule: for each strobe bit set in the new store, the data byte is replaced; strobe becomes old | new; count is unchanged.
  - push_ready = !full | merge_hit, so a merging store is accepted even when full.
- STORE_BUF_MERGE_EN undefined: every store allocates; push_ready = !full.

## Test plan
- Strobe generation:
  - SB at 0x1003, wd 0xAB000000 → dreq_addr 0x1000, dreq_strobe 4'b1000, dreq_data 0xAB000000, one cycle after push.
  - SH at 0x2002 → strobe 4'b1100.
  - SW at 0x3000 → strobe 4'b1111.
- Fill and backpressure: with dreq_ready=0, push 4 SWs (0x10, 0x20, 0x30, 0x40) → count 4, push_ready 0, a 5th push is refused. Then dreq_ready=1 for 4 cycles → pops occur in order 0x10…0x40, then empty=1.
- Simultaneous push and pop at count 2 → count stays 2 and order is preserved. At count 4 with a pop, a push offered that cycle is refused.
- Load conflict: buffer holds 0x100 and 0x200.
  - ld_addr 0x203 → ld_conflict=1.
  - ld_addr 0x300 → ld_conflict=0.
  - After 0x200 is popped, ld_addr 0x203 → 0.
- Merge (macro on): dreq_ready=0; push SW 0x0 = 0x11111111, then SB 0x8 = 0x22, then SB 0x9 = 0x3300 → count 2, tail data 0x00003322, strobe 4'b0011. With the macro off, count is 3.
- Reset mid-drain: 3 entries, dreq_ready toggling; assert resetn=0 → dreq_valid, count and data outputs are 0 immediately; after release, push_ready=1.
